// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle one-bit-per-clock shifter (LL/LR/AR/ROR)
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   synchronous active-high reset
//   start   in   request pulse, accepted in IDLE or DONE
//   mode    in   00 LL, 01 LR, 10 AR, 11 ROR (latched on accept)
//   din     in   operand (latched on accept)
//   amount  in   shift count 0..WIDTH-1 (latched on accept)
//   hold    in   stall, only effective while shifting
//   busy    out  high while shifting
//   done    out  one-cycle completion pulse
//   result  out  shift register contents
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amount,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] M_LL  = 2'b00;
  localparam logic [1:0] M_LR  = 2'b01;
  localparam logic [1:0] M_AR  = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] step_val;

  // One-position shift of the current contents under the latched mode.
  always_comb begin
    step_val = result_q;
    case (mode_q)
      M_LL:    step_val = {result_q[WIDTH-2:0], 1'b0};
      M_LR:    step_val = {1'b0, result_q[WIDTH-1:1]};
      M_AR:    step_val = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      default: step_val = {result_q[0], result_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    case (state_q)
      S_SHIFT: begin
        if (!hold) begin
          result_d = step_val;
          cnt_d    = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE falls back to IDLE.
        if (start) begin
          result_d = din;
          cnt_d    = amount;
          mode_d   = mode;
          state_d  = (amount != '0) ? S_SHIFT : S_DONE;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      cnt_q    <= '0;
      mode_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
    end
  end

  // Decoded straight from the state register, so done is registered and
  // busy/done are mutually exclusive by construction.
  assign busy   = (state_q == S_SHIFT);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
